// File: rtl/cam_entry_ctrl_if.sv
// Command, response and CAM-port signals of cam_entry_ctrl bundled as one interface.
// slave = the controller, master = command issuer plus CAM.
interface cam_entry_ctrl_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 5,
   parameter int SLICE_WIDTH = 4
) ();
   localparam int SLICES = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;

   // Both handshakes are strict valid/ready: a transfer happens on a rising clock edge
   // where valid && ready; once raised, valid and its payload hold until that edge.
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_op;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic [SLICES-1:0]     cmd_mask;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [1:0]            resp_status;
   logic [ADDR_WIDTH-1:0] resp_addr;
   logic [ADDR_WIDTH-1:0] cam_write_addr;
   logic [DATA_WIDTH-1:0] cam_write_data;
   logic                  cam_write_delete;
   logic                  cam_write_enable;
   logic [SLICES-1:0]     cam_select_mask;
   logic                  cam_write_busy;
   logic                  cam_setup;
   logic [DATA_WIDTH-1:0] cam_compare_data;
   logic                  cam_match;
   logic [ADDR_WIDTH-1:0] cam_match_addr;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_mask, resp_ready,
      output cam_write_busy, cam_setup, cam_match, cam_match_addr,
      input  cmd_ready, resp_valid, resp_status, resp_addr,
      input  cam_write_addr, cam_write_data, cam_write_delete, cam_write_enable,
      input  cam_select_mask, cam_compare_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_mask, resp_ready,
      input  cam_write_busy, cam_setup, cam_match, cam_match_addr,
      output cmd_ready, resp_valid, resp_status, resp_addr,
      output cam_write_addr, cam_write_data, cam_write_delete, cam_write_enable,
      output cam_select_mask, cam_compare_data
   );
endinterface

// File: rtl/cam_entry_ctrl.sv
// Insert/delete front-end for a CAM: looks up every key, allocates the lowest free entry,
// tracks occupancy. Define CAM_ENTRY_CTRL_STATS_EN to add saturating statistics counters.
module cam_entry_ctrl #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 5,
   parameter int SLICE_WIDTH = 4,
   parameter int LOOKUP_LAT  = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   cam_entry_ctrl_if.slave     bus,
   output logic [ADDR_WIDTH:0] occupancy_o,
   output logic                full_o,
   output logic [2:0]          state_o
`ifdef CAM_ENTRY_CTRL_STATS_EN
   ,
   output logic [15:0]         stat_inserts_o,
   output logic [15:0]         stat_deletes_o,
   output logic [15:0]         stat_rejects_o
`endif
);
   localparam int SLICES  = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
   localparam int ENTRIES = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] ENTRIES_C = (ADDR_WIDTH+1)'(ENTRIES);
   localparam logic [ADDR_WIDTH:0] OCC_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [2:0] LAT_C = 3'(LOOKUP_LAT);

   localparam logic [1:0] ST_OK        = 2'd0;
   localparam logic [1:0] ST_DUPLICATE = 2'd1;
   localparam logic [1:0] ST_FULL      = 2'd2;
   localparam logic [1:0] ST_NOT_FOUND = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_DECIDE    = 3'd2,
      S_WRITE     = 3'd3,
      S_WAIT_BUSY = 3'd4,
      S_RESP      = 3'd5
   } state_t;

   state_t                state_q;
   logic [2:0]            lat_cnt_q;
   logic                  wait_first_q;
   logic                  op_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [SLICES-1:0]     mask_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            status_q;
   logic                  cmd_ready_q;
   logic                  resp_valid_q;
   logic                  wr_en_q;
   logic                  wr_del_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [SLICES-1:0]     wr_mask_q;
   logic [ENTRIES-1:0]    bitmap_q;
   logic [ADDR_WIDTH:0]   occ_q;

   logic [ADDR_WIDTH-1:0] free_addr_d;
   logic                  full_d;
   logic [1:0]            dec_status_d;
   logic [ADDR_WIDTH-1:0] dec_addr_d;
   logic                  dec_write_d;

   assign full_d = (occ_q == ENTRIES_C);

   // Lowest clear bitmap bit; only consulted when not full, so a clear bit exists.
   always_comb begin
      free_addr_d = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!bitmap_q[i]) free_addr_d = ADDR_WIDTH'(i);
      end
   end

   always_comb begin
      dec_status_d = ST_OK;
      dec_addr_d   = '0;
      dec_write_d  = 1'b0;
      if (!op_q) begin
         if (bus.cam_match) begin
            dec_status_d = ST_DUPLICATE;
            dec_addr_d   = bus.cam_match_addr;
         end else if (full_d) begin
            dec_status_d = ST_FULL;
         end else begin
            dec_addr_d  = free_addr_d;
            dec_write_d = 1'b1;
         end
      end else if (bus.cam_match) begin
         dec_addr_d  = bus.cam_match_addr;
         dec_write_d = 1'b1;
      end else begin
         dec_status_d = ST_NOT_FOUND;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         lat_cnt_q    <= '0;
         wait_first_q <= 1'b0;
         op_q         <= 1'b0;
         data_q       <= '0;
         mask_q       <= '0;
         addr_q       <= '0;
         status_q     <= '0;
         cmd_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_del_q     <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_mask_q    <= '0;
         bitmap_q     <= '0;
         occ_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid && cmd_ready_q) begin
                  op_q        <= bus.cmd_op;
                  data_q      <= bus.cmd_data;
                  mask_q      <= bus.cmd_mask;
                  lat_cnt_q   <= 3'd1;
                  cmd_ready_q <= 1'b0;
                  state_q     <= S_LOOKUP;
               end else begin
                  cmd_ready_q <= !bus.cam_setup;
               end
            end
            S_LOOKUP: begin
               if (lat_cnt_q == LAT_C) state_q <= S_DECIDE;
               else                    lat_cnt_q <= lat_cnt_q + 3'd1;
            end
            S_DECIDE: begin
               status_q <= dec_status_d;
               addr_q   <= dec_addr_d;
               if (dec_write_d) begin
                  wr_en_q   <= 1'b1;
                  wr_del_q  <= op_q;
                  wr_addr_q <= dec_addr_d;
                  wr_data_q <= data_q;
                  wr_mask_q <= op_q ? {SLICES{1'b1}} : mask_q;
                  state_q   <= S_WRITE;
               end else begin
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end
            end
            S_WRITE: begin
               wr_en_q      <= 1'b0;
               wr_del_q     <= 1'b0;
               wr_addr_q    <= '0;
               wr_data_q    <= '0;
               wr_mask_q    <= '0;
               wait_first_q <= 1'b1;
               state_q      <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               // The CAM raises busy a cycle after the write pulse, so the first cycle is blind.
               wait_first_q <= 1'b0;
               if (!wait_first_q && !bus.cam_write_busy) begin
                  if (!op_q) begin
                     if (!bitmap_q[addr_q]) begin
                        bitmap_q[addr_q] <= 1'b1;
                        occ_q            <= occ_q + OCC_ONE;
                     end
                  end else if (bitmap_q[addr_q]) begin
                     bitmap_q[addr_q] <= 1'b0;
                     occ_q            <= occ_q - OCC_ONE;
                  end
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  cmd_ready_q  <= !bus.cam_setup;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready        = cmd_ready_q;
   assign bus.resp_valid       = resp_valid_q;
   assign bus.resp_status      = status_q;
   assign bus.resp_addr        = addr_q;
   assign bus.cam_write_addr   = wr_addr_q;
   assign bus.cam_write_data   = wr_data_q;
   assign bus.cam_write_delete = wr_del_q;
   assign bus.cam_write_enable = wr_en_q;
   assign bus.cam_select_mask  = wr_mask_q;
   assign bus.cam_compare_data = data_q;
   assign occupancy_o          = occ_q;
   assign full_o               = full_d;
   assign state_o              = state_q;

`ifdef CAM_ENTRY_CTRL_STATS_EN
   logic [15:0] stat_ins_q;
   logic [15:0] stat_del_q;
   logic [15:0] stat_rej_q;
   logic        resp_fire;

   assign resp_fire = resp_valid_q && bus.resp_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_ins_q <= '0;
         stat_del_q <= '0;
         stat_rej_q <= '0;
      end else if (resp_fire) begin
         if (status_q != ST_OK) begin
            if (stat_rej_q != 16'hFFFF) stat_rej_q <= stat_rej_q + 16'd1;
         end else if (op_q) begin
            if (stat_del_q != 16'hFFFF) stat_del_q <= stat_del_q + 16'd1;
         end else begin
            if (stat_ins_q != 16'hFFFF) stat_ins_q <= stat_ins_q + 16'd1;
         end
      end
   end

   assign stat_inserts_o = stat_ins_q;
   assign stat_deletes_o = stat_del_q;
   assign stat_rejects_o = stat_rej_q;
`endif
endmodule
